booth_mult8_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one booth_mult8 instance among NREQ requesters. It accepts operand requests over valid/ready, issues a one-cycle start pulse, and waits for done, with a cycle timeout. It returns the 16-bit product tagged with the requester ID over a valid/ready response channel. It sits between the client blocks and the single multiplier datapath.

---
 rtl/booth_mult8_arbiter.sv | 172 +++++++++++++++++
 tb/tb_booth_mult8_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult8_arbiter.sv
// Round-robin arbiter and sequencer sharing one booth_mult8 among NREQ requesters.
// Optional BOOTH_ARB_STATS_EN adds saturating completion/timeout counters.
module booth_mult8_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [2*NREQ-1:0] req_sign,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_product,
  output logic              rsp_err,
  output logic              mult_start,
  output logic [7:0]        mult_multiplicand,
  output logic [7:0]        mult_multiplier,
  output logic [1:0]        mult_sign_mode,
  input  logic [15:0]       mult_product,
  input  logic              mult_done
`ifdef BOOTH_ARB_STATS_EN
  ,
  output logic [15:0]       stat_ops,
  output logic [7:0]        stat_timeouts
`endif
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic [1:0]       r_sign;
  logic [CW-1:0]    r_cnt;
  logic [15:0]      r_product;
  logic             r_err;

  logic             w_grantValid;
  logic [IDW-1:0]   w_grantIdx;
  logic [IDW-1:0]   w_cand;
  logic             w_accept;
  logic             w_capture;
  logic             w_timeout;
  logic             w_rspFire;

  // Scan from ptr+NREQ down to ptr+1 so the candidate nearest ptr+1 is written last and wins.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    w_cand       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = IDW'((int'(r_ptr) + k) % NREQ);
      if (req_valid[w_cand]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = '0;
    mult_start = 1'b0;
    rsp_valid  = 1'b0;
    w_accept   = 1'b0;
    w_capture  = 1'b0;
    w_timeout  = 1'b0;
    w_rspFire  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grantValid) begin
          req_ready[w_grantIdx] = 1'b1;
          w_accept              = 1'b1;
          w_next                = ISSUE;
        end
      end
      ISSUE: begin
        mult_start = 1'b1;
        w_next     = WAIT;
      end
      WAIT: begin
        if (mult_done) begin
          w_capture = 1'b1;
          w_next    = RESP;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_rspFire = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Done has priority over the timeout when both land in the same WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= IDW'(NREQ - 1);
      r_id      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_sign    <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a    <= req_a[{w_grantIdx, 3'b000} +: 8];
        r_b    <= req_b[{w_grantIdx, 3'b000} +: 8];
        r_sign <= req_sign[{w_grantIdx, 1'b0} +: 2];
        r_id   <= w_grantIdx;
      end
      if (r_state == ISSUE)
        r_cnt <= '0;
      else if (r_state == WAIT && !mult_done)
        r_cnt <= r_cnt + 1'b1;
      if (w_capture) begin
        r_product <= mult_product;
        r_err     <= 1'b0;
      end else if (w_timeout) begin
        r_product <= '0;
        r_err     <= 1'b1;
      end
      if (w_rspFire)
        r_ptr <= r_id;
    end
  end

  assign rsp_id            = r_id;
  assign rsp_product       = r_product;
  assign rsp_err           = r_err;
  assign mult_multiplicand = r_a;
  assign mult_multiplier   = r_b;
  assign mult_sign_mode    = r_sign;

`ifdef BOOTH_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops      <= '0;
      stat_timeouts <= '0;
    end else if (w_rspFire) begin
      if (r_err) begin
        if (stat_timeouts != 8'hFF) stat_timeouts <= stat_timeouts + 1'b1;
      end else begin
        if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_booth_mult8_arbiter.sv
// Directed, table-driven bench for booth_mult8_arbiter with a behavioural multiplier stub.
module tb_booth_mult8_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [2*NREQ-1:0] req_sign;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_product;
  logic              rsp_err;
  logic              mult_start;
  logic [7:0]        mult_multiplicand;
  logic [7:0]        mult_multiplier;
  logic [1:0]        mult_sign_mode;
  logic [15:0]       mult_product;
  logic              mult_done;

  int testsRun   = 0;
  int testsFail  = 0;
  int startCount = 0;
  int oneHotErr  = 0;

  int latency    = 2;
  bit deadMode   = 1'b0;
  bit staleDone  = 1'b0;
  bit stubBusy   = 1'b0;
  int stubLat    = 0;

  typedef struct {
    int          req;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  sign;
    int          lat;
    bit          stale;
    logic [15:0] expProd;
    logic        expErr;
  } vec_t;

  vec_t vecs[10];

  booth_mult8_arbiter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_a             (req_a),
    .req_b             (req_b),
    .req_sign          (req_sign),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_id            (rsp_id),
    .rsp_product       (rsp_product),
    .rsp_err           (rsp_err),
    .mult_start        (mult_start),
    .mult_multiplicand (mult_multiplicand),
    .mult_multiplier   (mult_multiplier),
    .mult_sign_mode    (mult_sign_mode),
    .mult_product      (mult_product),
    .mult_done         (mult_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mulModel(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
    logic [15:0] ea;
    logic [15:0] eb;
    ea = s[1] ? {{8{a[7]}}, a} : {8'h00, a};
    eb = s[0] ? {{8{b[7]}}, b} : {8'h00, b};
    return ea * eb;
  endfunction

  // Multiplier stub: answers `latency` cycles after the start pulse, optionally with a stale done during ISSUE.
  always @(negedge clk) begin
    mult_done = 1'b0;
    if (stubBusy) begin
      stubLat = stubLat - 1;
      if (stubLat == 0) begin
        stubBusy = 1'b0;
        if (!deadMode) begin
          mult_done    = 1'b1;
          mult_product = mulModel(mult_multiplicand, mult_multiplier, mult_sign_mode);
        end
      end
    end
    if (mult_start) begin
      stubBusy = 1'b1;
      stubLat  = latency;
      if (staleDone) begin
        mult_done    = 1'b1;
        mult_product = 16'hDEAD;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (mult_start) startCount++;
    if ($countones(req_ready) > 1) oneHotErr++;
    if (rsp_valid && req_ready != '0) oneHotErr++;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    stubBusy  = 1'b0;
    deadMode  = 1'b0;
    staleDone = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic setOperands(input int req, input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
    req_a[8*req +: 8]    = a;
    req_b[8*req +: 8]    = b;
    req_sign[2*req +: 2] = s;
  endtask

  task automatic applyStimulus(input int req, input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
    bit granted;
    granted = 1'b0;
    setOperands(req, a, b, s);
    req_valid[req] = 1'b1;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (req_ready[req]) begin
        granted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!granted) begin
      testsFail++;
      $display("[TB] FAIL grant: req %0d never granted", req);
    end
    @(posedge clk);
    #1 req_valid[req] = 1'b0;
  endtask

  task automatic waitResp();
    int n;
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    testsRun++;
    if (!rsp_valid) begin
      testsFail++;
      $display("[TB] FAIL rspTimeout: got no response, required rsp_valid=1");
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    int s0;
    int waitCycles;
    int holdBad;
    int sawRsp;
    int rrOrder[5];

    vecs[0] = '{0, 8'h05, 8'h03, 2'b00, 2,  1'b0, 16'h000F, 1'b0};
    vecs[1] = '{2, 8'hFF, 8'h80, 2'b11, 1,  1'b0, 16'h0080, 1'b0};
    vecs[2] = '{1, 8'h80, 8'hFF, 2'b10, 3,  1'b1, 16'h8080, 1'b0};
    vecs[3] = '{3, 8'hFF, 8'hFF, 2'b00, 4,  1'b0, 16'hFE01, 1'b0};
    vecs[4] = '{0, 8'h7F, 8'h7F, 2'b11, 2,  1'b1, 16'h3F01, 1'b0};
    vecs[5] = '{1, 8'hFF, 8'hFF, 2'b11, 1,  1'b0, 16'h0001, 1'b0};
    vecs[6] = '{2, 8'h80, 8'h80, 2'b11, 5,  1'b0, 16'h4000, 1'b0};
    vecs[7] = '{3, 8'h0C, 8'hFD, 2'b01, 2,  1'b0, 16'hFFDC, 1'b0};
    vecs[8] = '{1, 8'h03, 8'h07, 2'b00, 64, 1'b0, 16'h0015, 1'b0};
    vecs[9] = '{2, 8'h03, 8'h07, 2'b00, 65, 1'b0, 16'h0000, 1'b1};

    req_a        = '0;
    req_b        = '0;
    req_sign     = '0;
    mult_product = '0;
    mult_done    = 1'b0;
    doReset();
    #1;
    checkOutput("resetState",
                {rsp_valid, rsp_id, rsp_product, rsp_err, mult_start,
                 mult_multiplicand, mult_multiplier, mult_sign_mode, req_ready}, 64'h0);

    for (int i = 0; i < 10; i++) begin
      latency   = vecs[i].lat;
      staleDone = vecs[i].stale;
      s0        = startCount;
      @(negedge clk);
      applyStimulus(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].sign);
      waitResp();
      checkOutput($sformatf("vec%0d.id", i), 64'(rsp_id), 64'(vecs[i].req));
      checkOutput($sformatf("vec%0d.product", i), 64'(rsp_product), 64'(vecs[i].expProd));
      checkOutput($sformatf("vec%0d.err", i), 64'(rsp_err), 64'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d.startPulses", i), 64'(startCount - s0), 64'd1);
      handshake();
      @(negedge clk);
      #1;
      checkOutput($sformatf("vec%0d.validDrop", i), 64'(rsp_valid), 64'd0);
    end
    staleDone = 1'b0;

    // Backpressure: response held ten cycles while another requester waits.
    latency = 2;
    @(negedge clk);
    applyStimulus(2, 8'h11, 8'h02, 2'b00);
    waitResp();
    setOperands(1, 8'h04, 8'h05, 2'b00);
    req_valid[1] = 1'b1;
    holdBad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (!rsp_valid || rsp_id != 2'd2 || rsp_product != 16'h0022 || rsp_err || req_ready != '0)
        holdBad++;
    end
    checkOutput("holdStable", 64'(holdBad), 64'd0);
    handshake();
    @(negedge clk);
    #1;
    checkOutput("holdNextGrant", 64'(req_ready), 64'b0010);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    waitResp();
    checkOutput("holdNext.id", 64'(rsp_id), 64'd1);
    checkOutput("holdNext.product", 64'(rsp_product), 64'h0014);
    handshake();

    // Dead multiplier: count WAIT cycles until the timeout response.
    deadMode = 1'b1;
    @(negedge clk);
    applyStimulus(0, 8'h01, 8'h01, 2'b00);
    @(negedge clk);
    #1;
    checkOutput("timeoutIssue", 64'(mult_start), 64'd1);
    waitCycles = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) break;
      waitCycles++;
    end
    checkOutput("timeoutWaitCycles", 64'(waitCycles), 64'd64);
    checkOutput("timeout.err", 64'(rsp_err), 64'd1);
    checkOutput("timeout.product", 64'(rsp_product), 64'h0);
    handshake();
    deadMode = 1'b0;
    @(negedge clk);
    applyStimulus(0, 8'h06, 8'h07, 2'b00);
    waitResp();
    checkOutput("afterTimeout.product", 64'(rsp_product), 64'h002A);
    checkOutput("afterTimeout.err", 64'(rsp_err), 64'd0);
    handshake();

    // Round-robin from reset with every requester held valid.
    doReset();
    latency = 1;
    for (int r = 0; r < NREQ; r++) setOperands(r, 8'(r + 1), 8'h02, 2'b00);
    rrOrder = '{0, 1, 2, 3, 0};
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      waitResp();
      checkOutput($sformatf("rr%0d.id", k), 64'(rsp_id), 64'(rrOrder[k]));
      checkOutput($sformatf("rr%0d.product", k), 64'(rsp_product), 64'((rrOrder[k] + 1) * 2));
      if (k == 4) req_valid = '0;
      handshake();
    end

    // Async reset in WAIT: no response, then lowest valid index wins.
    deadMode = 1'b1;
    @(negedge clk);
    applyStimulus(3, 8'h09, 8'h09, 2'b00);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midReset",
                {rsp_valid, rsp_id, rsp_product, rsp_err, mult_start,
                 mult_multiplicand, mult_multiplier, mult_sign_mode, req_ready}, 64'h0);
    @(negedge clk);
    stubBusy = 1'b0;
    deadMode = 1'b0;
    rst_n    = 1'b1;
    sawRsp   = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) sawRsp++;
    end
    checkOutput("noRspAfterReset", 64'(sawRsp), 64'd0);
    setOperands(1, 8'h02, 8'h03, 2'b00);
    setOperands(3, 8'h05, 8'h05, 2'b00);
    req_valid = 4'b1010;
    #1;
    checkOutput("postResetGrant", 64'(req_ready), 64'b0010);
    waitResp();
    checkOutput("postReset1.id", 64'(rsp_id), 64'd1);
    checkOutput("postReset1.product", 64'(rsp_product), 64'h0006);
    handshake();
    waitResp();
    checkOutput("postReset3.id", 64'(rsp_id), 64'd3);
    checkOutput("postReset3.product", 64'(rsp_product), 64'h0019);
    req_valid = '0;
    handshake();

    repeat (2) @(negedge clk);
    checkOutput("readyOneHot", 64'(oneHotErr), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
